multicycle_controller: RTL and testbench

Main control FSM for the multi-cycle RV32I core. It sequences one shared ALU, the unified instruction/data memory port, and the register file through fetch, decode, execute, memory and writeback steps. It generates the 2-bit ALU_op that the ALU decoder expands, plus all mux selects and write enables. It also resolves branch outcomes, stalls on memory handshakes, and keeps a retired-instruction counter.

---
 rtl/multicycle_controller.sv | 252 +++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM for a multi-cycle RV32I core. It steps one shared ALU, the
// unified instruction/data memory port and the register file through the
// fetch, decode, execute, memory and writeback steps. It also resolves branch
// outcomes, stalls on memory handshakes and counts retired instructions.
//
// Ports
//   clock                 system clock, rising edge
//   reset                 synchronous, active-high
//   opcode[6:0]           instruction bits [6:0] from the instruction register
//   funct3[2:0]           instruction bits [14:12]
//   zero                  ALU result == 0
//   alu_lsb               ALU result bit 0 (slt/sltu outcome)
//   memory_ready          memory completes the current access this cycle
//   PC_write              PC register load enable
//   address_select        0=PC, 1=result bus
//   memory_write          memory write strobe
//   IR_write              instruction register (and old_PC) load enable
//   register_write        register file write enable
//   result_select[1:0]    00=ALU_out reg, 01=data reg, 10=ALU result direct
//   ALU_select_A[1:0]     00=PC, 01=old_PC, 10=rs1
//   ALU_select_B[1:0]     00=rs2, 01=immediate, 10=constant 4
//   ALU_op[1:0]           00=add, 01=branch compare, 10=funct-decoded
//   immediate_select[2:0] 000=I, 001=S, 010=B, 011=J
//   illegal_instruction   one-cycle pulse on an unsupported opcode
//   instructions_retired  retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic                     zero,
  input  logic                     alu_lsb,
  input  logic                     memory_ready,
  output logic                     PC_write,
  output logic                     address_select,
  output logic                     memory_write,
  output logic                     IR_write,
  output logic                     register_write,
  output logic [1:0]               result_select,
  output logic [1:0]               ALU_select_A,
  output logic [1:0]               ALU_select_B,
  output logic [1:0]               ALU_op,
  output logic [2:0]               immediate_select,
  output logic                     illegal_instruction,
  output logic [COUNTER_WIDTH-1:0] instructions_retired
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // slt/sltu comparisons leave their outcome in alu_lsb; beq/bne use zero.
  // funct3 010/011 are not branch encodings and never redirect the PC.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic       z,
                                        input logic       lsb);
    logic t;
    case (f3)
      3'b000:         t = z;
      3'b001:         t = ~z;
      3'b100, 3'b110: t = lsb;
      3'b101, 3'b111: t = ~lsb;
      default:        t = 1'b0;
    endcase
    return t;
  endfunction

  logic [3:0]               state_q, state_d;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic                     retire_s;
  logic                     pc_write_s;
  logic                     memory_write_s;
  logic                     ir_write_s;
  logic                     register_write_s;
  logic                     illegal_s;

  // Next state, retirement and all per-state control outputs.
  always_comb begin
    state_d          = state_q;
    retire_s         = 1'b0;
    pc_write_s       = 1'b0;
    memory_write_s   = 1'b0;
    ir_write_s       = 1'b0;
    register_write_s = 1'b0;
    illegal_s        = 1'b0;
    address_select   = 1'b0;
    result_select    = 2'b00;
    ALU_select_A     = 2'b00;
    ALU_select_B     = 2'b00;
    ALU_op           = 2'b00;
    case (state_q)
      FETCH: begin
        // ALU computes PC+4 and it is written straight back as the new PC.
        ALU_select_B  = 2'b10;
        result_select = 2'b10;
        ir_write_s    = memory_ready;
        pc_write_s    = memory_ready;
        if (memory_ready) begin
          state_d = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        // old_PC + imm is latched into ALU_out for a later branch/jal.
        ALU_select_A = 2'b01;
        ALU_select_B = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECUTER;
          OP_ITYPE:          state_d = EXECUTEI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          default: begin
            illegal_s = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALU_select_A = 2'b10;
        ALU_select_B = 2'b01;
        // opcode[5] separates store (0100011) from load (0000011).
        if (opcode[5]) begin
          state_d = MEMWRITE;
        end else begin
          state_d = MEMREAD;
        end
      end
      MEMREAD: begin
        address_select = 1'b1;
        if (memory_ready) begin
          state_d = MEMWB;
        end else begin
          state_d = MEMREAD;
        end
      end
      MEMWB: begin
        result_select    = 2'b01;
        register_write_s = 1'b1;
        retire_s         = 1'b1;
        state_d          = FETCH;
      end
      MEMWRITE: begin
        address_select = 1'b1;
        memory_write_s = 1'b1;
        if (memory_ready) begin
          retire_s = 1'b1;
          state_d  = FETCH;
        end else begin
          state_d  = MEMWRITE;
        end
      end
      EXECUTER: begin
        ALU_select_A = 2'b10;
        ALU_op       = 2'b10;
        state_d      = ALUWB;
      end
      EXECUTEI: begin
        ALU_select_A = 2'b10;
        ALU_select_B = 2'b01;
        ALU_op       = 2'b10;
        state_d      = ALUWB;
      end
      ALUWB: begin
        register_write_s = 1'b1;
        retire_s         = 1'b1;
        state_d          = FETCH;
      end
      BRANCH: begin
        // PC loads the target held in ALU_out only when the compare says so.
        ALU_select_A = 2'b10;
        ALU_op       = 2'b01;
        pc_write_s   = branch_taken(funct3, zero, alu_lsb);
        retire_s     = 1'b1;
        state_d      = FETCH;
      end
      JAL: begin
        // PC takes the target from ALU_out while the ALU forms old_PC+4,
        // which ALUWB then writes to rd.
        ALU_select_A = 2'b01;
        ALU_select_B = 2'b10;
        pc_write_s   = 1'b1;
        state_d      = ALUWB;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Immediate format follows the opcode directly, independent of state.
  always_comb begin
    case (opcode)
      OP_STORE:  immediate_select = 3'b001;
      OP_BRANCH: immediate_select = 3'b010;
      OP_JAL:    immediate_select = 3'b011;
      default:   immediate_select = 3'b000;
    endcase
  end

  // Retired-instruction count advances on the same edge that returns to FETCH.
  always_comb begin
    if (retire_s) begin
      count_d = count_q + COUNTER_WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      count_q <= {COUNTER_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Every write-type enable is suppressed while reset is high so an aborted
  // instruction leaves no architectural side effects.
  assign PC_write             = pc_write_s       & ~reset;
  assign memory_write         = memory_write_s   & ~reset;
  assign IR_write             = ir_write_s       & ~reset;
  assign register_write       = register_write_s & ~reset;
  assign illegal_instruction  = illegal_s        & ~reset;
  assign instructions_retired = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. Each instruction is expanded into its list
// of steps from the opcode; every clock cycle the expected controls for the
// current step are compared with the DUT outputs.
module tb_multicycle_controller;

  localparam int CW = 4;

  typedef enum int {
    ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMREAD, ST_MEMWB, ST_MEMWRITE,
    ST_EXEC_R, ST_EXEC_I, ST_ALUWB, ST_BRANCH, ST_JAL
  } step_e;

  logic          clock = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          zero;
  logic          alu_lsb;
  logic          memory_ready;
  logic          PC_write, address_select, memory_write, IR_write;
  logic          register_write, illegal_instruction;
  logic [1:0]    result_select, ALU_select_A, ALU_select_B, ALU_op;
  logic [2:0]    immediate_select;
  logic [CW-1:0] instructions_retired;

  int            vectors     = 0;
  int            miscompares = 0;
  logic [CW-1:0] model_count = '0;

  multicycle_controller #(.COUNTER_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
    .zero(zero), .alu_lsb(alu_lsb), .memory_ready(memory_ready),
    .PC_write(PC_write), .address_select(address_select),
    .memory_write(memory_write), .IR_write(IR_write),
    .register_write(register_write), .result_select(result_select),
    .ALU_select_A(ALU_select_A), .ALU_select_B(ALU_select_B),
    .ALU_op(ALU_op), .immediate_select(immediate_select),
    .illegal_instruction(illegal_instruction),
    .instructions_retired(instructions_retired)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_legal(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
           op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111;
  endfunction

  // Branch condition in instruction terms: beq, bne, blt/bltu, bge/bgeu.
  function automatic logic taken_ref(input logic [2:0] f3, input logic z,
                                     input logic lt);
    logic t;
    t = 1'b0;
    if (f3 == 3'd0) t = z;
    if (f3 == 3'd1) t = !z;
    if (f3 == 3'd4 || f3 == 3'd6) t = lt;
    if (f3 == 3'd5 || f3 == 3'd7) t = !lt;
    return t;
  endfunction

  function automatic logic [2:0] imm_ref(input logic [6:0] op);
    logic [2:0] r;
    r = 3'd0;
    if (op == 7'b0100011) r = 3'd1;
    if (op == 7'b1100011) r = 3'd2;
    if (op == 7'b1101111) r = 3'd3;
    return r;
  endfunction

  // Packed {PC_write, addr_sel, mem_write, IR_write, reg_write,
  //         result_sel, A, B, ALU_op, illegal}
  function automatic logic [13:0] exp_out(input step_e st, input logic rdy,
                                          input logic [6:0] op,
                                          input logic [2:0] f3,
                                          input logic z, input logic lt);
    logic pcw, asel, mw, irw, rw, ill;
    logic [1:0] rs, a, b, aop;
    pcw = 1'b0; asel = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; ill = 1'b0;
    rs = 2'd0; a = 2'd0; b = 2'd0; aop = 2'd0;
    case (st)
      ST_FETCH:    begin b = 2'd2; rs = 2'd2; irw = rdy; pcw = rdy; end
      ST_DECODE:   begin a = 2'd1; b = 2'd1; ill = !is_legal(op); end
      ST_MEMADR:   begin a = 2'd2; b = 2'd1; end
      ST_MEMREAD:  begin asel = 1'b1; end
      ST_MEMWB:    begin rs = 2'd1; rw = 1'b1; end
      ST_MEMWRITE: begin asel = 1'b1; mw = 1'b1; end
      ST_EXEC_R:   begin a = 2'd2; aop = 2'd2; end
      ST_EXEC_I:   begin a = 2'd2; b = 2'd1; aop = 2'd2; end
      ST_ALUWB:    begin rw = 1'b1; end
      ST_BRANCH:   begin a = 2'd2; aop = 2'd1; pcw = taken_ref(f3, z, lt); end
      ST_JAL:      begin a = 2'd1; b = 2'd2; pcw = 1'b1; end
      default:     begin end
    endcase
    return {pcw, asel, mw, irw, rw, rs, a, b, aop, ill};
  endfunction

  // One clock cycle: entered just after a falling edge, leaves at the next.
  task automatic run_step(input step_e st, input logic rdy, input logic rst);
    logic [13:0] got;
    memory_ready = rdy;
    reset        = rst;
    #2;
    got = {PC_write, address_select, memory_write, IR_write, register_write,
           result_select, ALU_select_A, ALU_select_B, ALU_op,
           illegal_instruction};
    if (rst) begin
      check_eq("enables_in_reset",
               {27'd0, PC_write, memory_write, IR_write, register_write,
                illegal_instruction}, 32'd0);
    end else begin
      check_eq($sformatf("controls_%s", st.name()), {18'd0, got},
               {18'd0, exp_out(st, rdy, opcode, funct3, zero, alu_lsb)});
      check_eq("immediate_select", {29'd0, immediate_select},
               {29'd0, imm_ref(opcode)});
      check_eq("instructions_retired", {{(32-CW){1'b0}}, instructions_retired},
               {{(32-CW){1'b0}}, model_count});
    end
    @(posedge clock);
    if (rst) model_count = '0;
    @(negedge clock);
  endtask

  // Runs one instruction. waits<0 picks random memory stall counts;
  // abort_at>=0 asserts reset at the first cycle of that step index.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic z, input logic lt, input int waits,
                           input int abort_at);
    step_e plan[$];
    int    w;
    opcode = op; funct3 = f3; zero = z; alu_lsb = lt;
    plan.push_back(ST_FETCH);
    plan.push_back(ST_DECODE);
    case (op)
      7'b0000011: begin plan.push_back(ST_MEMADR);
                        plan.push_back(ST_MEMREAD);
                        plan.push_back(ST_MEMWB); end
      7'b0100011: begin plan.push_back(ST_MEMADR);
                        plan.push_back(ST_MEMWRITE); end
      7'b0110011: begin plan.push_back(ST_EXEC_R);
                        plan.push_back(ST_ALUWB); end
      7'b0010011: begin plan.push_back(ST_EXEC_I);
                        plan.push_back(ST_ALUWB); end
      7'b1100011: plan.push_back(ST_BRANCH);
      7'b1101111: begin plan.push_back(ST_JAL);
                        plan.push_back(ST_ALUWB); end
      default:    begin end
    endcase
    foreach (plan[i]) begin
      if (i == abort_at) begin
        run_step(plan[i], 1'b0, 1'b1);
        return;
      end
      if (plan[i] == ST_FETCH || plan[i] == ST_MEMREAD ||
          plan[i] == ST_MEMWRITE) begin
        w = (waits < 0) ? $urandom_range(0, 3) : waits;
        for (int k = 0; k < w; k++) run_step(plan[i], 1'b0, 1'b0);
        run_step(plan[i], 1'b1, 1'b0);
      end else begin
        run_step(plan[i], 1'($urandom_range(0, 1)), 1'b0);
      end
    end
    if (is_legal(op)) model_count = model_count + 1'b1;
  endtask

  initial begin
    logic [6:0] op_r;
    int         kind;
    reset = 1'b1; memory_ready = 1'b0; opcode = 7'd0; funct3 = 3'd0;
    zero = 1'b0; alu_lsb = 1'b0;
    @(negedge clock);
    // Reset held two cycles with memory idle.
    run_step(ST_FETCH, 1'b0, 1'b1);
    run_step(ST_FETCH, 1'b0, 1'b1);
    // Released but memory not ready: parked in FETCH, no IR load.
    for (int k = 0; k < 3; k++) run_step(ST_FETCH, 1'b0, 1'b0);
    // R-type, no stalls.
    run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 0, -1);
    // Load with three stall cycles in MEMREAD (and fetch).
    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 3, -1);
    // Branches: beq taken / not taken, bge taken, bltu, non-branch funct3.
    run_instr(7'b1100011, 3'd0, 1'b1, 1'b0, 0, -1);
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b0, 0, -1);
    run_instr(7'b1100011, 3'd5, 1'b0, 1'b0, 0, -1);
    run_instr(7'b1100011, 3'd6, 1'b0, 1'b1, 0, -1);
    run_instr(7'b1100011, 3'd2, 1'b1, 1'b1, 0, -1);
    // Illegal opcode.
    run_instr(7'b0000000, 3'd0, 1'b0, 1'b0, 0, -1);
    // Store, jal, I-type.
    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 2, -1);
    run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, 0, -1);
    run_instr(7'b0010011, 3'd0, 1'b0, 1'b0, 0, -1);
    // Reset while a store waits in MEMWRITE; fetch restarts afterwards.
    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 0, 3);
    run_step(ST_FETCH, 1'b0, 1'b0);
    // Random instruction mix; counter wraps several times at CW=4.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 8);
      case (kind)
        0: op_r = 7'b0000011;
        1: op_r = 7'b0100011;
        2: op_r = 7'b0110011;
        3: op_r = 7'b0010011;
        4, 5: op_r = 7'b1100011;
        6: op_r = 7'b1101111;
        default: op_r = 7'($urandom_range(0, 127));
      endcase
      run_instr(op_r, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1,
                ($urandom_range(0, 24) == 0) ? $urandom_range(0, 4) : -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
